// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single common data bus (CDB) between N_SRC result producers.
//   Each producer owns a one-entry holding buffer. A round-robin scheduler picks
//   one buffered result per cycle and drives it as a registered broadcast
//   (valid/tag/data) to every tag-snooping consumer. A result sits in its
//   buffer for at least one cycle. With N_SRC sources competing, it waits at
//   most N_SRC cycles.
//
// Parameters:
//   Q_WIDTH      ROB tag width; tag 0 is reserved ("no dependency")
//   N_SRC        number of producers (>= 2)
//
// Ports:
//   clk_in       clock, all state updates on posedge
//   rst_in       asynchronous active-high reset
//   rdy_in       global ready; 0 freezes every register
//   flush_in     mispredict flush; discards all pending results
//   req_valid    per-source result valid
//   req_tag      per-source ROB tag, source i at [i*Q_WIDTH +: Q_WIDTH]
//   req_data     per-source result, source i at [i*32 +: 32]
//   req_ready    per-source accept (transfer when valid & ready)
//   cdb_valid    registered broadcast valid
//   cdb_tag      registered broadcast ROB tag
//   cdb_data     registered broadcast value
//   pending_cnt  number of occupied holding buffers
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter  int Q_WIDTH = 4,
    parameter  int N_SRC   = 2,
    localparam int PTR_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int CNT_W   = $clog2(N_SRC + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic [N_SRC-1:0]           req_valid,
    input  logic [N_SRC*Q_WIDTH-1:0]   req_tag,
    input  logic [N_SRC*32-1:0]        req_data,
    output logic [N_SRC-1:0]           req_ready,
    output logic                       cdb_valid,
    output logic [Q_WIDTH-1:0]         cdb_tag,
    output logic [31:0]                cdb_data,
    output logic [CNT_W-1:0]           pending_cnt
);

    logic [N_SRC-1:0]                 bufValid_q, bufValid_d;
    logic [N_SRC-1:0][Q_WIDTH-1:0]    bufTag_q, bufTag_d;
    logic [N_SRC-1:0][31:0]           bufData_q, bufData_d;
    logic [PTR_W-1:0]                 rrPtr_q, rrPtr_d;
    logic                             cdbValid_q, cdbValid_d;
    logic [Q_WIDTH-1:0]               cdbTag_q, cdbTag_d;
    logic [31:0]                      cdbData_q, cdbData_d;

    logic [N_SRC-1:0]                 grantVec;
    logic                             grantAny;
    logic [PTR_W-1:0]                 grantIdx;
    logic [N_SRC-1:0]                 acceptVec;
    logic [CNT_W-1:0]                 pendingCount;

    // Round-robin grant: walk the buffers starting at rrPtr_q, wrapping around,
    // and take the first occupied one. Only one grant is possible per cycle.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idxSel;
        grantVec = '0;
        grantAny = 1'b0;
        grantIdx = '0;
        idx      = 0;
        idxSel   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx    = (int'(rrPtr_q) + k) % N_SRC;
            idxSel = PTR_W'(idx);
            if (!grantAny && bufValid_q[idxSel]) begin
                grantAny         = 1'b1;
                grantIdx         = idxSel;
                grantVec[idxSel] = 1'b1;
            end
        end
    end

    // A source may hand over a result when its buffer is empty, or when that
    // buffer is draining onto the bus this very cycle. That lets one source
    // stream a result every cycle. Reset, flush and stall all block acceptance.
    assign req_ready = {N_SRC{rdy_in & ~flush_in & ~rst_in}} & (~bufValid_q | grantVec);
    assign acceptVec = req_valid & req_ready;

    // Next-state computation. The broadcast drains the granted buffer first.
    // New arrivals are applied afterwards, so a refill of the granted buffer
    // wins over its clear. Tag-0 results are accepted but never stored, so
    // they can never reach the bus.
    always_comb begin
        bufValid_d = bufValid_q;
        bufTag_d   = bufTag_q;
        bufData_d  = bufData_q;
        rrPtr_d    = rrPtr_q;
        cdbValid_d = 1'b0;
        cdbTag_d   = cdbTag_q;
        cdbData_d  = cdbData_q;

        if (grantAny) begin
            cdbValid_d           = 1'b1;
            cdbTag_d             = bufTag_q[grantIdx];
            cdbData_d            = bufData_q[grantIdx];
            bufValid_d[grantIdx] = 1'b0;
            rrPtr_d              = (int'(grantIdx) == N_SRC - 1) ? '0 : grantIdx + 1'b1;
        end

        for (int j = 0; j < N_SRC; j++) begin
            if (acceptVec[j]) begin
                bufTag_d[j]   = req_tag[j*Q_WIDTH +: Q_WIDTH];
                bufData_d[j]  = req_data[j*32 +: 32];
                bufValid_d[j] = (req_tag[j*Q_WIDTH +: Q_WIDTH] != '0);
            end
        end
    end

    // State registers. Flush overrides the global stall. It empties the
    // buffers and kills the broadcast, but leaves the round-robin pointer
    // where it was. With rdy_in low, everything holds, including cdb_valid.
    // The frozen consumers therefore see the held broadcast exactly once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bufValid_q <= '0;
            bufTag_q   <= '0;
            bufData_q  <= '0;
            rrPtr_q    <= '0;
            cdbValid_q <= 1'b0;
            cdbTag_q   <= '0;
            cdbData_q  <= '0;
        end else if (flush_in) begin
            bufValid_q <= '0;
            cdbValid_q <= 1'b0;
        end else if (rdy_in) begin
            bufValid_q <= bufValid_d;
            bufTag_q   <= bufTag_d;
            bufData_q  <= bufData_d;
            rrPtr_q    <= rrPtr_d;
            cdbValid_q <= cdbValid_d;
            cdbTag_q   <= cdbTag_d;
            cdbData_q  <= cdbData_d;
        end
    end

    // Occupancy count is a pure function of the buffer valid bits.
    always_comb begin
        pendingCount = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pendingCount = pendingCount + CNT_W'(bufValid_q[i]);
        end
    end

    assign cdb_valid   = cdbValid_q;
    assign cdb_tag     = cdbTag_q;
    assign cdb_data    = cdbData_q;
    assign pending_cnt = pendingCount;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Purpose:
//   Directed testbench for cdb_arbiter with Q_WIDTH=4 and N_SRC=2.
//   Stimulus pushes each expected broadcast into a queue. A monitor pops from
//   the queue whenever the bus presents a new broadcast and compares it.
//   Direct checks cover reset, ready, stall and flush behaviour.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int QW = 4;
    localparam int NS = 2;

    logic          clk_in    = 1'b0;
    logic          rst_in    = 1'b0;
    logic          rdy_in    = 1'b1;
    logic          flush_in  = 1'b0;
    logic [NS-1:0] req_valid = '0;
    logic [NS*QW-1:0] req_tag = '0;
    logic [NS*32-1:0] req_data = '0;
    logic [NS-1:0] req_ready;
    logic          cdb_valid;
    logic [QW-1:0] cdb_tag;
    logic [31:0]   cdb_data;
    logic [1:0]    pending_cnt;

    typedef struct {
        logic [QW-1:0] tag;
        logic [31:0]   data;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    logic edgeLive   = 1'b0;

    cdb_arbiter #(.Q_WIDTH(QW), .N_SRC(NS)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .pending_cnt(pending_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                                 input logic [3:0] t1, input logic [31:0] d1);
        req_valid = v;
        req_tag   = {t1, t0};
        req_data  = {d1, d0};
    endtask

    task automatic pushExp(input logic [3:0] t, input logic [31:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic nextCycle;
        @(posedge clk_in);
        #1;
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles && expQ.size() > 0; i++) nextCycle();
        repeat (3) nextCycle();
        checkOutput("drain_left", 64'(expQ.size()), 64'd0);
    endtask

    // Remember whether the last edge actually advanced the design. A broadcast
    // held through a stall is then scored only once.
    always @(posedge clk_in) edgeLive <= rdy_in && !rst_in;

    // Scoreboard monitor: every fresh broadcast must match the oldest expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (edgeLive && cdb_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_broadcast: got tag 0x%0h data 0x%0h, expected none", cdb_tag, cdb_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                checkOutput("cdb_data", 64'(cdb_data), 64'(e.data));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k0;
        int k1;
        logic [1:0] expR;

        // Reset state, with requests presented during reset.
        #1 rst_in = 1'b1;
        applyStimulus(2'b11, 4'h1, 32'h1, 4'h2, 32'h2);
        #1;
        checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        checkOutput("reset_cdb_tag", 64'(cdb_tag), 64'd0);
        checkOutput("reset_cdb_data", 64'(cdb_data), 64'd0);
        checkOutput("reset_pending", 64'(pending_cnt), 64'd0);
        checkOutput("reset_ready", 64'(req_ready), 64'd0);
        nextCycle();
        checkOutput("reset_ready_edge", 64'(req_ready), 64'd0);
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(negedge clk_in) rst_in = 1'b0;
        nextCycle();

        // Single source: accept at edge 1, broadcast after edge 2, gone after edge 3.
        applyStimulus(2'b01, 4'h3, 32'hDEADBEEF, 4'h0, 32'h0);
        pushExp(4'h3, 32'hDEADBEEF);
        #1 checkOutput("single_ready", 64'(req_ready), 64'b11);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("single_pending", 64'(pending_cnt), 64'd1);
        checkOutput("single_early_valid", 64'(cdb_valid), 64'd0);
        nextCycle();
        checkOutput("single_valid", 64'(cdb_valid), 64'd1);
        checkOutput("single_tag", 64'(cdb_tag), 64'd3);
        checkOutput("single_pending_after", 64'(pending_cnt), 64'd0);
        nextCycle();
        checkOutput("single_valid_drop", 64'(cdb_valid), 64'd0);

        // Back-to-back single source: tags 1..8 on src1 every cycle.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(2'b10, 4'h0, 32'h0, 4'(i), 32'h1000_0000 + 32'(i));
            pushExp(4'(i), 32'h1000_0000 + 32'(i));
            #1 checkOutput("b2b_ready1", 64'(req_ready[1]), 64'd1);
            if (i >= 3) begin
                checkOutput("b2b_valid", 64'(cdb_valid), 64'd1);
                checkOutput("b2b_tag", 64'(cdb_tag), 64'(i - 2));
            end
            nextCycle();
        end
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        waitDrain(20);

        // Contention: both sources always valid, rr pointer at 0 -> alternate grants.
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(2'b11, 4'(1 + k0 % 7), 32'hA000_0000 + 32'(k0),
                                 4'(8 + k1 % 7), 32'hB000_0000 + 32'(k1));
            #1;
            expR = (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b01 : 2'b10);
            checkOutput("contention_ready", 64'(req_ready), 64'(expR));
            if (req_ready[0]) begin
                pushExp(4'(1 + k0 % 7), 32'hA000_0000 + 32'(k0));
                k0++;
            end
            if (req_ready[1]) begin
                pushExp(4'(8 + k1 % 7), 32'hB000_0000 + 32'(k1));
                k1++;
            end
            nextCycle();
        end
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("contention_accepts", 64'(k0 + k1), 64'd101);
        waitDrain(10);

        // Flush with both buffers full; same-cycle requests are refused.
        applyStimulus(2'b11, 4'hC, 32'hCCCC_000C, 4'hD, 32'hDDDD_000D);
        #1 checkOutput("flush_fill_ready", 64'(req_ready), 64'b11);
        nextCycle();
        flush_in = 1'b1;
        applyStimulus(2'b11, 4'hE, 32'hEEEE_000E, 4'hF, 32'hFFFF_000F);
        #1;
        checkOutput("flush_pending_before", 64'(pending_cnt), 64'd2);
        checkOutput("flush_ready", 64'(req_ready), 64'd0);
        nextCycle();
        flush_in = 1'b0;
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
        checkOutput("flush_pending", 64'(pending_cnt), 64'd0);
        waitDrain(5);

        // Stall with tag 5 on the bus, then a tag-0 request.
        applyStimulus(2'b01, 4'h5, 32'h5555_0005, 4'h0, 32'h0);
        pushExp(4'h5, 32'h5555_0005);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        nextCycle();
        checkOutput("stall_pre_valid", 64'(cdb_valid), 64'd1);
        rdy_in = 1'b0;
        applyStimulus(2'b10, 4'h0, 32'h0, 4'h6, 32'h6666_0006);
        #1 checkOutput("stall_ready", 64'(req_ready), 64'd0);
        for (int s = 0; s < 3; s++) begin
            nextCycle();
            checkOutput("stall_valid", 64'(cdb_valid), 64'd1);
            checkOutput("stall_tag", 64'(cdb_tag), 64'd5);
            checkOutput("stall_data", 64'(cdb_data), 64'h5555_0005);
            checkOutput("stall_ready_hold", 64'(req_ready), 64'd0);
        end
        rdy_in = 1'b1;
        pushExp(4'h6, 32'h6666_0006);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("stall_release_valid", 64'(cdb_valid), 64'd0);
        nextCycle();
        applyStimulus(2'b01, 4'h0, 32'h0000_1234, 4'h0, 32'h0);
        #1 checkOutput("tag0_ready", 64'(req_ready[0]), 64'd1);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("tag0_pending", 64'(pending_cnt), 64'd0);
        nextCycle();
        checkOutput("tag0_no_broadcast", 64'(cdb_valid), 64'd0);
        waitDrain(5);

        // Asynchronous reset in the middle of a broadcast with a result still pending.
        applyStimulus(2'b11, 4'h7, 32'h7777_0007, 4'h9, 32'h9999_0009);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        checkOutput("midrst_pending_before", 64'(pending_cnt), 64'd2);
        nextCycle();
        checkOutput("midrst_valid_before", 64'(cdb_valid), 64'd1);
        checkOutput("midrst_tag_before", 64'(cdb_tag), 64'd7);
        rst_in = 1'b1;
        applyStimulus(2'b11, 4'h1, 32'h1, 4'h2, 32'h2);
        #1;
        checkOutput("midrst_valid", 64'(cdb_valid), 64'd0);
        checkOutput("midrst_pending", 64'(pending_cnt), 64'd0);
        checkOutput("midrst_ready", 64'(req_ready), 64'd0);
        nextCycle();
        applyStimulus(2'b00, 4'h0, 32'h0, 4'h0, 32'h0);
        @(negedge clk_in) rst_in = 1'b0;
        waitDrain(5);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
